// File: rtl/pipe_forward_history_pkg.sv
// Shared constants for the MEM-stage store-data forwarding unit: opcodes,
// default history entry field widths and the stall FSM state encoding.
package pipe_fwd_pkg;

    localparam logic [5:0] OPC_LW = 6'b100011;
    localparam logic [5:0] OPC_SW = 6'b101011;

    // Default field widths of one history entry: {valid, rd, data}
    localparam int REG_W_DEF  = 5;
    localparam int DATA_W_DEF = 32;
    localparam int OPC_W_DEF  = 6;
    localparam int DEPTH_DEF  = 4;

    typedef enum logic {
        FS_RUN   = 1'b0,
        FS_STALL = 1'b1
    } fwdState_e;

    // fwd_src: 0 = live bypass, 1..DEPTH = history entry + 1, all-ones = miss
    function automatic int srcWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pipe_forward_history_if.sv
// Pipeline-side signal bundle of the store-data forwarding unit.
// Optional statistics outputs exist only when PIPE_FWD_STATS_EN is defined.
interface pipe_forward_history_if
    import pipe_fwd_pkg::*;
#(
    parameter int REG_W  = REG_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int OPC_W  = OPC_W_DEF
);
    localparam int SRC_W = srcWidth(DEPTH);

    logic              flush;
    logic              wb_valid;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic [OPC_W-1:0]  exmem_opcode;
    logic [REG_W-1:0]  exmem_rt;
    logic [DATA_W-1:0] exmem_rt_data;
    logic [OPC_W-1:0]  idex_opcode;
    logic [REG_W-1:0]  idex_rt;
    logic [REG_W-1:0]  ifid_rs;
    logic [REG_W-1:0]  ifid_rt;
    logic [DATA_W-1:0] store_data;
    logic              fwd_hit;
    logic [SRC_W-1:0]  fwd_src;
    logic              stall;
`ifdef PIPE_FWD_STATS_EN
    logic [15:0]       hit_count;
    logic [15:0]       stall_count;
`endif

    modport master (
        output flush, wb_valid, wb_rd, wb_data,
        output exmem_opcode, exmem_rt, exmem_rt_data,
        output idex_opcode, idex_rt, ifid_rs, ifid_rt,
`ifdef PIPE_FWD_STATS_EN
        input  hit_count, stall_count,
`endif
        input  store_data, fwd_hit, fwd_src, stall
    );

    modport slave (
        input  flush, wb_valid, wb_rd, wb_data,
        input  exmem_opcode, exmem_rt, exmem_rt_data,
        input  idex_opcode, idex_rt, ifid_rs, ifid_rt,
`ifdef PIPE_FWD_STATS_EN
        output hit_count, stall_count,
`endif
        output store_data, fwd_hit, fwd_src, stall
    );

endinterface

// File: rtl/pipe_forward_history_lookup.sv
// Combinational priority match of a register key against a live bypass
// and a DEPTH-entry writeback history (entry 0 newest).
module fwd_hist_lookup #(
    parameter int REG_W  = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int SRC_W  = 3
) (
    input  logic                         enable,
    input  logic [REG_W-1:0]             key,
    input  logic                         liveValid,
    input  logic [REG_W-1:0]             liveRd,
    input  logic [DATA_W-1:0]            liveData,
    input  logic [DEPTH-1:0]             entValid,
    input  logic [DEPTH-1:0][REG_W-1:0]  entRd,
    input  logic [DEPTH-1:0][DATA_W-1:0] entData,
    output logic                         hit,
    output logic [SRC_W-1:0]             index,
    output logic [DATA_W-1:0]            data
);

    always_comb begin
        hit   = 1'b0;
        index = '1;
        data  = '0;
        if (enable && key != '0) begin
            if (liveValid && liveRd == key) begin
                hit   = 1'b1;
                index = '0;
                data  = liveData;
            end else begin
                // Walk oldest to newest so the lowest matching index wins
                for (int i = DEPTH - 1; i >= 0; i--) begin
                    if (entValid[i] && entRd[i] == key) begin
                        hit   = 1'b1;
                        index = SRC_W'(i + 1);
                        data  = entData[i];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/pipe_forward_history.sv
// MEM-stage store-data forwarding from a writeback history, plus a one-cycle
// load-use stall request. Define PIPE_FWD_STATS_EN for hit/stall counters.
//
// state    | meaning
// FS_RUN   | normal flow, load-use hazard evaluated each cycle
// FS_STALL | stall=1 for one cycle, hazard masked, returns to FS_RUN
module pipe_forward_history
    import pipe_fwd_pkg::*;
#(
    parameter int              REG_W     = REG_W_DEF,
    parameter int              DATA_W    = DATA_W_DEF,
    parameter int              DEPTH     = DEPTH_DEF,
    parameter int              OPC_W     = OPC_W_DEF,
    parameter logic [OPC_W-1:0] STORE_OPC = OPC_W'(OPC_SW),
    parameter logic [OPC_W-1:0] LOAD_OPC  = OPC_W'(OPC_LW)
) (
    input logic clk,
    input logic rst_n,
    pipe_forward_history_if.slave bus
);
    localparam int SRC_W = srcWidth(DEPTH);

    logic [DEPTH-1:0]             histValid;
    logic [DEPTH-1:0][REG_W-1:0]  histRd;
    logic [DEPTH-1:0][DATA_W-1:0] histData;

    fwdState_e state, nextState;
    logic      isStore, push, hazard, lkHit;
    logic [SRC_W-1:0]  lkIndex;
    logic [DATA_W-1:0] lkData;

    assign isStore = bus.exmem_opcode == STORE_OPC;
    assign push    = bus.wb_valid && bus.wb_rd != '0;
    assign hazard  = bus.idex_opcode == LOAD_OPC && bus.idex_rt != '0 &&
                     (bus.idex_rt == bus.ifid_rs || bus.idex_rt == bus.ifid_rt);

    fwd_hist_lookup #(
        .REG_W (REG_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .SRC_W (SRC_W)
    ) uLookup (
        .enable   (isStore),
        .key      (bus.exmem_rt),
        .liveValid(bus.wb_valid),
        .liveRd   (bus.wb_rd),
        .liveData (bus.wb_data),
        .entValid (histValid),
        .entRd    (histRd),
        .entData  (histData),
        .hit      (lkHit),
        .index    (lkIndex),
        .data     (lkData)
    );

    assign bus.store_data = lkHit ? lkData : bus.exmem_rt_data;
    assign bus.fwd_hit    = lkHit;
    assign bus.fwd_src    = lkIndex;
    assign bus.stall      = state == FS_STALL;

    // Shifting also drops older copies of the pushed register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            histValid <= '0;
            histRd    <= '0;
            histData  <= '0;
        end else if (bus.flush) begin
            histValid <= '0;
        end else if (push) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                histValid[i] <= histValid[i-1] && histRd[i-1] != bus.wb_rd;
                histRd[i]    <= histRd[i-1];
                histData[i]  <= histData[i-1];
            end
            histValid[0] <= 1'b1;
            histRd[0]    <= bus.wb_rd;
            histData[0]  <= bus.wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         state <= FS_RUN;
        else if (bus.flush) state <= FS_RUN;
        else                state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            FS_RUN:   if (hazard) nextState = FS_STALL;
            FS_STALL: nextState = FS_RUN;
            default:  nextState = FS_RUN;
        endcase
    end

`ifdef PIPE_FWD_STATS_EN
    logic [15:0] hitCount, stallCount;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hitCount   <= '0;
            stallCount <= '0;
        end else if (bus.flush) begin
            hitCount   <= '0;
            stallCount <= '0;
        end else begin
            if (lkHit && hitCount != 16'hFFFF)        hitCount   <= hitCount + 16'd1;
            if (bus.stall && stallCount != 16'hFFFF) stallCount <= stallCount + 16'd1;
        end
    end

    assign bus.hit_count   = hitCount;
    assign bus.stall_count = stallCount;
`endif

endmodule

// File: tb/tb_pipe_forward_history.sv
// Self-checking bench: vector table with scoreboard for the forward path,
// hand sequences for stall, flush and asynchronous reset.
module tb_pipe_forward_history;
    import pipe_fwd_pkg::*;

    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] NOP = 6'b000000;
    localparam logic [2:0] MISS = 3'b111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_forward_history_if #(.REG_W(5), .DATA_W(32), .DEPTH(4), .OPC_W(6)) bus ();

    pipe_forward_history #(.REG_W(5), .DATA_W(32), .DEPTH(4), .OPC_W(6)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic        wbValid;
        logic [4:0]  wbRd;
        logic [31:0] wbData;
        logic [5:0]  opc;
        logic [4:0]  rt;
        logic [31:0] rtData;
        logic [31:0] expData;
        logic        expHit;
        logic [2:0]  expSrc;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        hit;
        logic [2:0]  src;
    } exp_t;

    vec_t vecs[21];
    exp_t expQ[$];
    int   nChecks = 0;
    int   nFail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.flush = 0; bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_data = 0;
        bus.exmem_opcode = NOP; bus.exmem_rt = 0; bus.exmem_rt_data = 0;
        bus.idex_opcode = NOP; bus.idex_rt = 0; bus.ifid_rs = 0; bus.ifid_rt = 0;
    endtask

    task automatic applyVec(input vec_t v, input int idx);
        exp_t e, got;
        @(negedge clk);
        bus.wb_valid = v.wbValid; bus.wb_rd = v.wbRd; bus.wb_data = v.wbData;
        bus.exmem_opcode = v.opc; bus.exmem_rt = v.rt; bus.exmem_rt_data = v.rtData;
        e.data = v.expData; e.hit = v.expHit; e.src = v.expSrc;
        expQ.push_back(e);
        #1;
        if (expQ.size() == 0) begin
            nChecks++; nFail++;
            $display("FAIL scoreboard_empty vec %0d: got 0 entries expected 1", idx);
        end else begin
            got = expQ.pop_front();
            check($sformatf("vec%0d_data", idx), bus.store_data, got.data);
            check($sformatf("vec%0d_hit", idx), {31'd0, bus.fwd_hit}, {31'd0, got.hit});
            check($sformatf("vec%0d_src", idx), {29'd0, bus.fwd_src}, {29'd0, got.src});
        end
    endtask

    // Store probe with no writeback, checked immediately
    task automatic probe(input string name, input logic [4:0] rt, input logic [31:0] rtData,
                         input logic [31:0] expData, input logic expHit, input logic [2:0] expSrc);
        bus.wb_valid = 0; bus.exmem_opcode = SW; bus.exmem_rt = rt; bus.exmem_rt_data = rtData;
        #1;
        check({name, "_data"}, bus.store_data, expData);
        check({name, "_hit"}, {31'd0, bus.fwd_hit}, {31'd0, expHit});
        check({name, "_src"}, {29'd0, bus.fwd_src}, {29'd0, expSrc});
    endtask

    initial begin
        vecs[0]  = '{0, 0, 0,            NOP, 0,  32'h1234, 32'h1234, 0, MISS};
        vecs[1]  = '{1, 1, 32'hAAAA0001, NOP, 1,  32'h55,   32'h55,   0, MISS};
        vecs[2]  = '{0, 0, 0,            SW,  1,  32'h0,    32'hAAAA0001, 1, 3'd1};
        vecs[3]  = '{1, 3, 32'h33,       SW,  3,  32'h99,   32'h33,   1, 3'd0};
        vecs[4]  = '{1, 5, 32'h10,       NOP, 0,  32'h1,    32'h1,    0, MISS};
        vecs[5]  = '{1, 5, 32'h20,       NOP, 0,  32'h2,    32'h2,    0, MISS};
        vecs[6]  = '{0, 0, 0,            SW,  5,  32'h3,    32'h20,   1, 3'd1};
        vecs[7]  = '{0, 0, 0,            SW,  3,  32'h4,    32'h33,   1, 3'd3};
        vecs[8]  = '{0, 0, 0,            SW,  1,  32'h5,    32'hAAAA0001, 1, 3'd4};
        vecs[9]  = '{1, 10, 32'hA0,      NOP, 0,  32'h0,    32'h0,    0, MISS};
        vecs[10] = '{1, 11, 32'hA1,      NOP, 0,  32'h0,    32'h0,    0, MISS};
        vecs[11] = '{1, 12, 32'hA2,      NOP, 0,  32'h0,    32'h0,    0, MISS};
        vecs[12] = '{1, 13, 32'hA3,      NOP, 0,  32'h0,    32'h0,    0, MISS};
        vecs[13] = '{0, 0, 0,            SW,  5,  32'hDEAD, 32'hDEAD, 0, MISS};
        vecs[14] = '{0, 0, 0,            SW,  10, 32'h6,    32'hA0,   1, 3'd4};
        vecs[15] = '{1, 0, 32'hFF,       SW,  0,  32'h77,   32'h77,   0, MISS};
        vecs[16] = '{0, 0, 0,            SW,  0,  32'h78,   32'h78,   0, MISS};
        vecs[17] = '{0, 0, 0,            SW,  13, 32'h7,    32'hA3,   1, 3'd1};
        vecs[18] = '{1, 13, 32'hB3,      SW,  13, 32'h8,    32'hB3,   1, 3'd0};
        vecs[19] = '{0, 0, 0,            LW,  13, 32'h5,    32'h5,    0, MISS};
        vecs[20] = '{0, 0, 0,            SW,  12, 32'h9,    32'hA2,   1, 3'd3};

        idle();
        bus.exmem_rt_data = 32'hCAFE0000;
        #1;
        check("reset_stall", {31'd0, bus.stall}, 32'd0);
        check("reset_data", bus.store_data, 32'hCAFE0000);
        check("reset_src", {29'd0, bus.fwd_src}, {29'd0, MISS});
        #12 rst_n = 1'b1;

        for (int i = 0; i < 21; i++) applyVec(vecs[i], i);
        @(negedge clk); idle();

        // Load-use hazard on rs: one stall cycle, held inputs do not re-trigger
        @(negedge clk);
        bus.idex_opcode = LW; bus.idex_rt = 7; bus.ifid_rs = 7;
        #1 check("stall_before_edge", {31'd0, bus.stall}, 32'd0);
        @(negedge clk); check("stall_raised", {31'd0, bus.stall}, 32'd1);
        @(negedge clk); check("stall_one_cycle", {31'd0, bus.stall}, 32'd0);
        idle();
        @(negedge clk); check("stall_stays_low", {31'd0, bus.stall}, 32'd0);

        // Hazard via rt; non-load and idex_rt==0 never stall
        bus.idex_opcode = LW; bus.idex_rt = 9; bus.ifid_rt = 9;
        @(negedge clk); check("stall_rt_match", {31'd0, bus.stall}, 32'd1);
        idle(); bus.idex_opcode = SW; bus.idex_rt = 4; bus.ifid_rs = 4;
        @(negedge clk); check("stall_not_load", {31'd0, bus.stall}, 32'd0);
        idle(); bus.idex_opcode = LW; bus.idex_rt = 0; bus.ifid_rs = 0;
        @(negedge clk); check("stall_rt_zero", {31'd0, bus.stall}, 32'd0);
        idle();

        // Fill history, then flush together with a push
        for (int r = 20; r < 24; r++) begin
            @(negedge clk);
            bus.wb_valid = 1; bus.wb_rd = 5'(r); bus.wb_data = 32'(r) << 8;
        end
        @(negedge clk); idle();
        probe("prefill_hit", 5'd20, 32'h1, 32'h1400, 1, 3'd4);
        @(negedge clk);
        bus.flush = 1; bus.wb_valid = 1; bus.wb_rd = 24; bus.wb_data = 32'h2424;
        @(negedge clk); idle();
        probe("flush_miss20", 5'd20, 32'hF0, 32'hF0, 0, MISS);
        probe("flush_miss23", 5'd23, 32'hF3, 32'hF3, 0, MISS);
        probe("flush_drop24", 5'd24, 32'hF4, 32'hF4, 0, MISS);

        // Flush clears a pending stall
        @(negedge clk); idle();
        bus.idex_opcode = LW; bus.idex_rt = 7; bus.ifid_rs = 7;
        @(negedge clk); check("pre_flush_stall", {31'd0, bus.stall}, 32'd1);
        idle(); bus.flush = 1;
        @(negedge clk); check("flush_stall", {31'd0, bus.stall}, 32'd0);
        idle();

        // Asynchronous reset mid-stall
        bus.wb_valid = 1; bus.wb_rd = 6; bus.wb_data = 32'h66;
        bus.idex_opcode = LW; bus.idex_rt = 7; bus.ifid_rt = 7;
        @(negedge clk); idle();
        check("pre_reset_stall", {31'd0, bus.stall}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_stall", {31'd0, bus.stall}, 32'd0);
        probe("reset_clears_hist", 5'd6, 32'h123, 32'h123, 0, MISS);
        @(negedge clk); rst_n = 1'b1; idle();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
